// File: rtl/mux_32_reg.sv
// Registered 2:1 word selector feeding the adder operand input.
// One-cycle latency from in1/in2/sel to out, with a valid flag raised after reset.
module mux_32_reg #(
  parameter int unsigned    WIDTH     = 32,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  // if/else rather than ?: so an unknown sel falls through to in1
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= RST_VALUE;
      out_valid <= 1'b0;
    end else begin
      if (sel == 1'b1) begin
        out <= in2;
      end else begin
        out <= in1;
      end
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_32_reg.sv
// Self-checking bench for mux_32_reg: directed scenarios plus randomized traffic
// compared against a behavioural model of the selector.
module tb_mux_32_reg;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             sel;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: what out/out_valid should hold after the last edge
  logic [WIDTH-1:0] exp_out;
  logic             exp_valid;

  mux_32_reg #(.WIDTH(WIDTH), .RST_VALUE('0)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .in1      (in1),
    .in2      (in2),
    .out      (out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and update the model from the inputs seen at that edge
  task automatic tick();
    logic [WIDTH-1:0] n;
    logic             v;
    if (rst === 1'b1) begin
      n = '0;
      v = 1'b0;
    end else begin
      n = (sel === 1'b1) ? in2 : in1;
      v = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_out   = n;
    exp_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b1; in1 = 32'd40; in2 = 32'd50;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out !== 32'd0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset cycle %0d: out=%h valid=%b, expected out=0 valid=0", i, out, out_valid);
      end
    end
  endtask

  task automatic test_sel_in1();
    rst = 1'b0; sel = 1'b0; in1 = 32'd40; in2 = 32'd50;
    tick();
    checks++;
    if (out !== 32'd40 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sel_in1: out=%0d valid=%b, expected out=40 valid=1", out, out_valid);
    end
  endtask

  task automatic test_sel_in2();
    sel = 1'b0;
    tick();
    sel = 1'b1;
    checks++;
    if (out !== 32'd40) begin
      errors++;
      $display("FAIL sel_in2_before: out=%0d, expected 40", out);
    end
    tick();
    checks++;
    if (out !== 32'd50 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sel_in2_after: out=%0d valid=%b, expected out=50 valid=1", out, out_valid);
    end
  endtask

  task automatic test_toggle();
    logic [WIDTH-1:0] want;
    for (int i = 0; i < 8; i++) begin
      sel  = 1'(i % 2);
      want = (i % 2 == 1) ? 32'd50 : 32'd40;
      tick();
      checks++;
      if (out !== want) begin
        errors++;
        $display("FAIL toggle step %0d: out=%0d, expected %0d", i, out, want);
      end
    end
  endtask

  task automatic test_hold();
    sel = 1'b0; in1 = 32'd40;
    tick();
    #2 in1 = 32'd7;
    #1;
    checks++;
    if (out !== 32'd40) begin
      errors++;
      $display("FAIL hold_glitch: out=%0d, expected 40", out);
    end
    in1 = 32'd40;
    tick();
    checks++;
    if (out !== 32'd40) begin
      errors++;
      $display("FAIL hold_after_edge: out=%0d, expected 40", out);
    end
  endtask

  task automatic test_mid_reset();
    sel = 1'b1;
    tick();
    checks++;
    if (out !== 32'd50) begin
      errors++;
      $display("FAIL midrst_pre: out=%0d, expected 50", out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out !== 32'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_assert: out=%0d valid=%b, expected out=0 valid=0", out, out_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (out !== 32'd50 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_release: out=%0d valid=%b, expected out=50 valid=1", out, out_valid);
    end
  endtask

  task automatic test_boundaries();
    sel = 1'b0; in1 = 32'hFFFF_FFFF; in2 = 32'd0;
    tick();
    checks++;
    if (out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL all_ones: out=%h, expected ffffffff", out);
    end
    sel = 1'b1;
    tick();
    checks++;
    if (out !== 32'd0) begin
      errors++;
      $display("FAIL zero: out=%h, expected 00000000", out);
    end
    sel = 1'bx; in1 = 32'h1234_5678; in2 = 32'h9ABC_DEF0;
    tick();
    checks++;
    if (out !== 32'h1234_5678) begin
      errors++;
      $display("FAIL sel_x: out=%h, expected 12345678", out);
    end
    sel = 1'bz; in1 = 32'hCAFE_F00D;
    tick();
    checks++;
    if (out !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL sel_z: out=%h, expected cafef00d", out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      sel = 1'($urandom_range(0, 1));
      in1 = $urandom;
      in2 = $urandom;
      tick();
      checks++;
      if (out !== exp_out || out_valid !== exp_valid) begin
        errors++;
        $display("FAIL random %0d: out=%h valid=%b, expected out=%h valid=%b",
                 i, out, out_valid, exp_out, exp_valid);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; in1 = '0; in2 = '0;
    exp_out = '0; exp_valid = 1'b0;
    test_reset();
    test_sel_in1();
    test_sel_in2();
    test_toggle();
    test_hold();
    test_mid_reset();
    test_boundaries();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
